// File: rtl/pipeline_hazard_ctrl_if.sv
// Issue-side inputs and hazard/status outputs of pipeline_hazard_ctrl.
// The master modport is the decode/issue side; the slave modport is the controller.
interface pipeline_hazard_ctrl_if #(
    parameter int FWD_DEPTH = 2,
    parameter int REG_AW    = 5
);
    localparam int FS_W = $clog2(FWD_DEPTH + 1);

    logic              i_issue_valid;
    logic [REG_AW-1:0] i_issue_rs;
    logic [REG_AW-1:0] i_issue_rt;
    logic              i_use_rs;
    logic              i_use_rt;
    logic              i_wr_en;
    logic [REG_AW-1:0] i_wr_addr;
    logic              i_is_load;
    logic              i_flush;
    logic              i_mem_req;
    logic              i_mem_ready;
    logic [FS_W-1:0]   o_fwd_sel_a;
    logic [FS_W-1:0]   o_fwd_sel_b;
    logic              o_stall;
    logic              o_bubble;
    logic              o_mem_error;
    logic [31:0]       o_stall_cnt;

    modport master (
        output i_issue_valid, i_issue_rs, i_issue_rt, i_use_rs, i_use_rt,
               i_wr_en, i_wr_addr, i_is_load, i_flush, i_mem_req, i_mem_ready,
        input  o_fwd_sel_a, o_fwd_sel_b, o_stall, o_bubble, o_mem_error, o_stall_cnt
    );

    modport slave (
        input  i_issue_valid, i_issue_rs, i_issue_rt, i_use_rs, i_use_rt,
               i_wr_en, i_wr_addr, i_is_load, i_flush, i_mem_req, i_mem_ready,
        output o_fwd_sel_a, o_fwd_sel_b, o_stall, o_bubble, o_mem_error, o_stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// MIPS150 operand-forwarding, load-use interlock and memory-wait stall controller.
// Optional stall performance counter enabled by defining HAZARD_PERF_EN.
//
// state  | meaning
// S_IDLE | no memory wait in progress
// S_WAIT | memory access outstanding, pipe stalled, watchdog counting down
// S_ERR  | watchdog expired, stall released, mem_error latched
module pipeline_hazard_ctrl #(
    parameter int FWD_DEPTH   = 2,
    parameter int LOAD_LAT    = 1,
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int FS_W  = $clog2(FWD_DEPTH + 1);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_mem_error;
    logic [FWD_DEPTH-1:0] r_valid;
    logic [FWD_DEPTH-1:0] r_load;
    logic [REG_AW-1:0] r_addr [FWD_DEPTH];

    logic [FS_W-1:0]   w_sel_a;
    logic [FS_W-1:0]   w_sel_b;
    logic              w_lu_a;
    logic              w_lu_b;
    logic              w_lu_stall;
    logic              w_mem_stall;

    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        w_lu_a  = 1'b0;
        w_lu_b  = 1'b0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (r_valid[k] && bus.i_use_rs && (bus.i_issue_rs != '0) &&
                (r_addr[k] == bus.i_issue_rs)) begin
                w_sel_a = FS_W'(k + 1);
                w_lu_a  = r_load[k] && (k < LOAD_LAT);
            end
            if (r_valid[k] && bus.i_use_rt && (bus.i_issue_rt != '0) &&
                (r_addr[k] == bus.i_issue_rt)) begin
                w_sel_b = FS_W'(k + 1);
                w_lu_b  = r_load[k] && (k < LOAD_LAT);
            end
        end
    end

    assign w_lu_stall  = w_lu_a | w_lu_b;
    assign w_mem_stall = ((r_state == S_IDLE) && bus.i_mem_req && !bus.i_mem_ready) ||
                         ((r_state == S_WAIT) && !bus.i_mem_ready);

    assign bus.o_fwd_sel_a = w_sel_a;
    assign bus.o_fwd_sel_b = w_sel_b;
    assign bus.o_stall     = w_mem_stall | w_lu_stall;
    assign bus.o_bubble    = w_lu_stall & ~w_mem_stall;
    assign bus.o_mem_error = r_mem_error;

    // Memory-wait watchdog is a down-counter holding the remaining wait cycles.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_mem_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_mem_req && !bus.i_mem_ready) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= CNT_W'(MEM_TIMEOUT - 1);
                    end
                end
                S_WAIT: begin
                    if (bus.i_mem_ready) begin
                        r_state    <= S_IDLE;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt <= CNT_W'(1)) begin
                        r_state     <= S_ERR;
                        r_wait_cnt  <= '0;
                        r_mem_error <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                    end
                end
                S_ERR: begin
                    if (bus.i_mem_req && bus.i_mem_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A load-use bubble shifts in an empty slot; the held instruction enters later.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= '0;
            r_load  <= '0;
            for (int k = 0; k < FWD_DEPTH; k++) begin
                r_addr[k] <= '0;
            end
        end else if (!w_mem_stall) begin
            for (int k = FWD_DEPTH - 1; k > 0; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_load[k]  <= r_load[k-1];
                r_addr[k]  <= r_addr[k-1];
            end
            r_valid[0] <= !w_lu_stall && bus.i_issue_valid && bus.i_wr_en &&
                          !bus.i_flush && (bus.i_wr_addr != '0);
            r_load[0]  <= bus.i_is_load;
            r_addr[0]  <= bus.i_wr_addr;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
        end else if (bus.o_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.o_stall_cnt = r_stall_cnt;
`else
    assign bus.o_stall_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (default and FWD_DEPTH=4/LOAD_LAT=2).
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.FWD_DEPTH(2), .REG_AW(5)) u_if ();
    pipeline_hazard_ctrl_if #(.FWD_DEPTH(4), .REG_AW(5)) u_if4 ();

    pipeline_hazard_ctrl #(.FWD_DEPTH(2), .LOAD_LAT(1), .REG_AW(5), .MEM_TIMEOUT(15)) u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (u_if.slave)
    );

    pipeline_hazard_ctrl #(.FWD_DEPTH(4), .LOAD_LAT(2), .REG_AW(5), .MEM_TIMEOUT(15)) u_dut4 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (u_if4.slave)
    );

`ifdef HAZARD_PERF_EN
    localparam int B2B_STALLS = 6;
`else
    localparam int B2B_STALLS = 0;
`endif

    task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic we,
                       input logic [4:0] wa, input logic ld, input logic fl);
        u_if.i_issue_valid = v;
        u_if.i_issue_rs    = rs;
        u_if.i_issue_rt    = rt;
        u_if.i_use_rs      = urs;
        u_if.i_use_rt      = urt;
        u_if.i_wr_en       = we;
        u_if.i_wr_addr     = wa;
        u_if.i_is_load     = ld;
        u_if.i_flush       = fl;
    endtask

    task automatic mem(input logic req, input logic rdy);
        u_if.i_mem_req   = req;
        u_if.i_mem_ready = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem(0, 0);
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem(0, 0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        drv(1, 5'd3, 5'd3, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        total++; if (u_if.o_fwd_sel_a !== 2'd0) begin bad++; $display("FAIL reset_fwd_a got=%0d exp=0", u_if.o_fwd_sel_a); end
        total++; if (u_if.o_fwd_sel_b !== 2'd0) begin bad++; $display("FAIL reset_fwd_b got=%0d exp=0", u_if.o_fwd_sel_b); end
        total++; if (u_if.o_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", u_if.o_stall); end
        total++; if (u_if.o_bubble !== 1'b0) begin bad++; $display("FAIL reset_bubble got=%0b exp=0", u_if.o_bubble); end
        total++; if (u_if.o_mem_error !== 1'b0) begin bad++; $display("FAIL reset_mem_error got=%0b exp=0", u_if.o_mem_error); end
        total++; if (u_if.o_stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", u_if.o_stall_cnt); end
        next_cycle();
        drain();
    endtask

    task automatic test_forward();
        drv(1, 0, 0, 0, 0, 1, 5'd3, 0, 0);                  // addiu $3
        @(negedge clk);
        total++; if (u_if.o_stall !== 1'b0) begin bad++; $display("FAIL fwd_prod_stall got=%0b exp=0", u_if.o_stall); end
        next_cycle();
        drv(1, 5'd3, 5'd3, 1, 1, 1, 5'd4, 0, 0);            // addu $4,$3,$3
        @(negedge clk);
        total++; if (u_if.o_fwd_sel_a !== 2'd1) begin bad++; $display("FAIL fwd_a got=%0d exp=1", u_if.o_fwd_sel_a); end
        total++; if (u_if.o_fwd_sel_b !== 2'd1) begin bad++; $display("FAIL fwd_b got=%0d exp=1", u_if.o_fwd_sel_b); end
        total++; if (u_if.o_stall !== 1'b0) begin bad++; $display("FAIL fwd_stall got=%0b exp=0", u_if.o_stall); end
        next_cycle();
        drv(1, 5'd3, 5'd4, 1, 1, 0, 0, 0, 0);               // $3 now at entry 1, $4 at entry 0
        @(negedge clk);
        total++; if (u_if.o_fwd_sel_a !== 2'd2) begin bad++; $display("FAIL fwd_age_a got=%0d exp=2", u_if.o_fwd_sel_a); end
        total++; if (u_if.o_fwd_sel_b !== 2'd1) begin bad++; $display("FAIL fwd_age_b got=%0d exp=1", u_if.o_fwd_sel_b); end
        next_cycle();
        drain();
    endtask

    task automatic test_load_use();
        drv(1, 0, 0, 0, 0, 1, 5'd5, 1, 0);                  // lw $5
        next_cycle();
        drv(1, 5'd5, 5'd0, 1, 1, 1, 5'd6, 0, 0);            // addu $6,$5,$0
        @(negedge clk);
        total++; if (u_if.o_stall !== 1'b1) begin bad++; $display("FAIL lu_c1_stall got=%0b exp=1", u_if.o_stall); end
        total++; if (u_if.o_bubble !== 1'b1) begin bad++; $display("FAIL lu_c1_bubble got=%0b exp=1", u_if.o_bubble); end
        next_cycle();
        @(negedge clk);
        total++; if (u_if.o_fwd_sel_a !== 2'd2) begin bad++; $display("FAIL lu_c2_fwd_a got=%0d exp=2", u_if.o_fwd_sel_a); end
        total++; if (u_if.o_fwd_sel_b !== 2'd0) begin bad++; $display("FAIL lu_c2_fwd_b got=%0d exp=0", u_if.o_fwd_sel_b); end
        total++; if (u_if.o_stall !== 1'b0) begin bad++; $display("FAIL lu_c2_stall got=%0b exp=0", u_if.o_stall); end
        total++; if (u_if.o_bubble !== 1'b0) begin bad++; $display("FAIL lu_c2_bubble got=%0b exp=0", u_if.o_bubble); end
        next_cycle();
        drain();
    endtask

    task automatic test_zero_youngest();
        drv(1, 0, 0, 0, 0, 1, 5'd0, 0, 0);                  // write $0
        next_cycle();
        drv(1, 5'd0, 5'd0, 1, 1, 1, 5'd3, 0, 0);            // read $0, write $3
        @(negedge clk);
        total++; if (u_if.o_fwd_sel_a !== 2'd0) begin bad++; $display("FAIL zero_fwd_a got=%0d exp=0", u_if.o_fwd_sel_a); end
        total++; if (u_if.o_fwd_sel_b !== 2'd0) begin bad++; $display("FAIL zero_fwd_b got=%0d exp=0", u_if.o_fwd_sel_b); end
        next_cycle();
        drv(1, 0, 0, 0, 0, 1, 5'd3, 1, 0);                  // second $3 producer (a load)
        next_cycle();
        drv(1, 5'd3, 5'd3, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        total++; if (u_if.o_fwd_sel_a !== 2'd1) begin bad++; $display("FAIL young_fwd_a got=%0d exp=1", u_if.o_fwd_sel_a); end
        total++; if (u_if.o_fwd_sel_b !== 2'd1) begin bad++; $display("FAIL young_fwd_b got=%0d exp=1", u_if.o_fwd_sel_b); end
        total++; if (u_if.o_bubble !== 1'b1) begin bad++; $display("FAIL young_lu_bubble got=%0b exp=1", u_if.o_bubble); end
        next_cycle();
        drain();
    endtask

    task automatic test_mem_wait();
        drv(1, 0, 0, 0, 0, 1, 5'd5, 1, 0);                  // lw $5
        next_cycle();
        drv(1, 5'd5, 5'd0, 1, 0, 1, 5'd6, 0, 0);
        mem(1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (u_if.o_stall !== 1'b1) begin bad++; $display("FAIL mw_stall[%0d] got=%0b exp=1", i, u_if.o_stall); end
            total++; if (u_if.o_bubble !== 1'b0) begin bad++; $display("FAIL mw_bubble[%0d] got=%0b exp=0", i, u_if.o_bubble); end
            total++; if (u_if.o_fwd_sel_a !== 2'd1) begin bad++; $display("FAIL mw_frozen_fwd[%0d] got=%0d exp=1", i, u_if.o_fwd_sel_a); end
            next_cycle();
        end
        mem(1, 1);
        @(negedge clk);
        total++; if (u_if.o_stall !== 1'b1) begin bad++; $display("FAIL mw_rdy_stall got=%0b exp=1", u_if.o_stall); end
        total++; if (u_if.o_bubble !== 1'b1) begin bad++; $display("FAIL mw_rdy_bubble got=%0b exp=1", u_if.o_bubble); end
        next_cycle();
        mem(0, 0);
        @(negedge clk);
        total++; if (u_if.o_stall !== 1'b0) begin bad++; $display("FAIL mw_after_stall got=%0b exp=0", u_if.o_stall); end
        total++; if (u_if.o_fwd_sel_a !== 2'd2) begin bad++; $display("FAIL mw_after_fwd got=%0d exp=2", u_if.o_fwd_sel_a); end
        next_cycle();
        drain();
    endtask

    task automatic test_timeout();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem(1, 0);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            total++; if (u_if.o_stall !== 1'b1) begin bad++; $display("FAIL to_stall[%0d] got=%0b exp=1", i, u_if.o_stall); end
            total++; if (u_if.o_mem_error !== 1'b0) begin bad++; $display("FAIL to_err_early[%0d] got=%0b exp=0", i, u_if.o_mem_error); end
            next_cycle();
        end
        @(negedge clk);
        total++; if (u_if.o_stall !== 1'b0) begin bad++; $display("FAIL to_err_stall got=%0b exp=0", u_if.o_stall); end
        total++; if (u_if.o_mem_error !== 1'b1) begin bad++; $display("FAIL to_err_flag got=%0b exp=1", u_if.o_mem_error); end
        next_cycle();
        mem(1, 1);                                           // ERR -> IDLE
        next_cycle();
        mem(1, 0);
        @(negedge clk);
        total++; if (u_if.o_stall !== 1'b1) begin bad++; $display("FAIL to_idle_stall got=%0b exp=1", u_if.o_stall); end
        total++; if (u_if.o_mem_error !== 1'b1) begin bad++; $display("FAIL to_sticky got=%0b exp=1", u_if.o_mem_error); end
        next_cycle();
        rst = 1'b1;                                          // reset while in WAIT
        mem(0, 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        total++; if (u_if.o_mem_error !== 1'b0) begin bad++; $display("FAIL to_rst_err got=%0b exp=0", u_if.o_mem_error); end
        total++; if (u_if.o_stall !== 1'b0) begin bad++; $display("FAIL to_rst_stall got=%0b exp=0", u_if.o_stall); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem(0, 0);
        next_cycle();
        rst = 1'b0;
        drv(1, 0, 0, 0, 0, 1, 5'd5, 1, 0);
        next_cycle();
        drv(1, 5'd5, 5'd0, 1, 1, 1, 5'd6, 0, 0);
        next_cycle();                                        // bubble cycle
        next_cycle();                                        // addu issues
        drv(1, 0, 0, 0, 0, 1, 5'd5, 1, 0);
        next_cycle();
        drv(1, 5'd5, 5'd0, 1, 0, 1, 5'd6, 0, 0);
        mem(1, 0);
        for (int i = 0; i < 4; i++) next_cycle();
        mem(1, 1);
        next_cycle();
        mem(0, 0);
        next_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++; if (u_if.o_stall_cnt !== 32'(B2B_STALLS)) begin bad++; $display("FAIL b2b_stall_cnt got=%0d exp=%0d", u_if.o_stall_cnt, B2B_STALLS); end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        total++; if (u_if.o_stall_cnt !== 32'd0) begin bad++; $display("FAIL b2b_rst_cnt got=%0d exp=0", u_if.o_stall_cnt); end
        next_cycle();
    endtask

    task automatic test_flush();
        drv(1, 0, 0, 0, 0, 1, 5'd5, 1, 0);                  // lw $5
        next_cycle();
        drv(1, 5'd5, 5'd0, 1, 0, 1, 5'd7, 0, 1);            // squashed dependent write to $7
        @(negedge clk);
        total++; if (u_if.o_bubble !== 1'b1) begin bad++; $display("FAIL fl_bubble got=%0b exp=1", u_if.o_bubble); end
        next_cycle();
        @(negedge clk);
        total++; if (u_if.o_stall !== 1'b0) begin bad++; $display("FAIL fl_c2_stall got=%0b exp=0", u_if.o_stall); end
        next_cycle();
        drv(1, 5'd7, 5'd0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++; if (u_if.o_fwd_sel_a !== 2'd0) begin bad++; $display("FAIL fl_never_entered got=%0d exp=0", u_if.o_fwd_sel_a); end
        next_cycle();
        drain();
    endtask

    task automatic test_depth4();
        u_if4.i_issue_valid = 1; u_if4.i_wr_en = 1; u_if4.i_wr_addr = 5'd5; u_if4.i_is_load = 1;
        next_cycle();
        u_if4.i_issue_valid = 0; u_if4.i_wr_en = 0; u_if4.i_is_load = 0;
        next_cycle();
        u_if4.i_issue_valid = 1; u_if4.i_issue_rs = 5'd5; u_if4.i_use_rs = 1;
        @(negedge clk);
        total++; if (u_if4.o_stall !== 1'b1) begin bad++; $display("FAIL d4_e1_stall got=%0b exp=1", u_if4.o_stall); end
        total++; if (u_if4.o_bubble !== 1'b1) begin bad++; $display("FAIL d4_e1_bubble got=%0b exp=1", u_if4.o_bubble); end
        next_cycle();
        @(negedge clk);
        total++; if (u_if4.o_stall !== 1'b0) begin bad++; $display("FAIL d4_e2_stall got=%0b exp=0", u_if4.o_stall); end
        total++; if (u_if4.o_fwd_sel_a !== 3'd3) begin bad++; $display("FAIL d4_e2_fwd_a got=%0d exp=3", u_if4.o_fwd_sel_a); end
        total++; if (u_if4.o_fwd_sel_b !== 3'd0) begin bad++; $display("FAIL d4_e2_fwd_b got=%0d exp=0", u_if4.o_fwd_sel_b); end
        next_cycle();
        u_if4.i_issue_valid = 0; u_if4.i_use_rs = 0;
    endtask

    initial begin
        u_if4.i_issue_valid = 0; u_if4.i_issue_rs = 0; u_if4.i_issue_rt = 0;
        u_if4.i_use_rs = 0; u_if4.i_use_rt = 0; u_if4.i_wr_en = 0; u_if4.i_wr_addr = 0;
        u_if4.i_is_load = 0; u_if4.i_flush = 0; u_if4.i_mem_req = 0; u_if4.i_mem_ready = 0;
        test_reset();
        test_forward();
        test_load_use();
        test_zero_youngest();
        test_mem_wait();
        test_timeout();
        test_back_to_back();
        test_flush();
        test_depth4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit");
    end
endmodule
